// File: rtl/packet_transmitter.sv
// BLE link-layer packet serialiser: preamble, access address, streamed PDU, CRC-24.
// Whitening of PDU and CRC is built only when PACKET_TX_WHITEN_EN is defined.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// IDLE       | waiting for a legal start; outputs quiet
// PREAMBLE   | 8 alternating bits seeded by acc_addr[31]
// ACCESS     | 32 access-address bits, MSB first; byte prefetch begins
// PDU        | 8*pdu_len bits, each byte MSB first, CRC accumulates
// CRC        | 24 CRC bits, then one extra strobe that raises done
module packet_transmitter #(
    parameter logic [23:0] CRC_POLY    = 24'h00065B,
    parameter logic [23:0] CRC_INIT    = 24'h555555,
    parameter int          PDU_LEN_MAX = 257
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        symbol_clk,
    input  logic        start,
    input  logic [31:0] acc_addr,
    input  logic [5:0]  channel,
    input  logic [8:0]  pdu_len,
    input  logic [7:0]  pdu_data,
    input  logic        pdu_valid,
    output logic        pdu_ready,
    output logic        symbol_out,
    output logic        tx_active,
    output logic        busy,
    output logic        done,
    output logic        underrun
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PREAMBLE = 3'd1;
    localparam logic [2:0] S_ACCESS   = 3'd2;
    localparam logic [2:0] S_PDU      = 3'd3;
    localparam logic [2:0] S_CRC      = 3'd4;
    localparam logic [8:0] LEN_MAX    = 9'(PDU_LEN_MAX);

    logic [2:0]  state;
    logic [4:0]  bit_cnt;
    logic [8:0]  byte_cnt;
    logic [8:0]  fetch_cnt;
    logic [8:0]  len_q;
    logic [31:0] aa_q;
    logic [23:0] crc;
    logic [7:0]  cur_byte;
    logic [7:0]  fifo [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  fifo_cnt;

    logic        strobe;
    logic        start_ok;
    logic        push;
    logic        boundary;
    logic        pop;
    logic        starve;
    logic        pdu_bit;
    logic        crc_fb;
    logic [23:0] crc_next;
    logic        white;

    assign strobe    = en && symbol_clk;
    assign busy      = (state != S_IDLE);
    assign start_ok  = en && start && (state == S_IDLE) &&
                       (pdu_len >= 9'd2) && (pdu_len <= LEN_MAX);
    assign pdu_ready = en && ((state == S_ACCESS) || (state == S_PDU)) &&
                       (fifo_cnt != 2'd2) && (fetch_cnt < len_q);
    assign push      = pdu_valid && pdu_ready;
    assign boundary  = strobe && (state == S_PDU) && (bit_cnt[2:0] == 3'd0);
    assign pop       = boundary && (fifo_cnt != 2'd0);
    // A byte arriving on the same cycle as its boundary strobe is too late.
    assign starve    = boundary && (fifo_cnt == 2'd0);
    assign pdu_bit   = (bit_cnt[2:0] == 3'd0) ? fifo[rd_ptr][7] : cur_byte[7];
    assign crc_fb    = crc[23] ^ pdu_bit;
    assign crc_next  = {crc[22:0], 1'b0} ^ (crc_fb ? CRC_POLY : 24'h000000);

`ifdef PACKET_TX_WHITEN_EN
    logic [6:0] lfsr;
    logic       adv_white;

    assign white     = lfsr[0];
    assign adv_white = strobe && (((state == S_PDU) && !starve) ||
                                  ((state == S_CRC) && (bit_cnt != 5'd24)));

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 7'd0;
        end else if (start_ok) begin
            lfsr <= {1'b1, channel};
        end else if (adv_white) begin
            lfsr <= {lfsr[0], lfsr[6:4], lfsr[3] ^ lfsr[0], lfsr[2:1]};
        end
    end
`else
    logic unused_channel;

    assign white          = 1'b0;
    assign unused_channel = ^channel;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wr_ptr] <= pdu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            bit_cnt    <= 5'd0;
            byte_cnt   <= 9'd0;
            fetch_cnt  <= 9'd0;
            len_q      <= 9'd0;
            aa_q       <= 32'd0;
            crc        <= 24'd0;
            cur_byte   <= 8'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_cnt   <= 2'd0;
            symbol_out <= 1'b0;
            tx_active  <= 1'b0;
            done       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            done     <= 1'b0;
            underrun <= 1'b0;
            if (push) begin
                wr_ptr    <= ~wr_ptr;
                fetch_cnt <= fetch_cnt + 9'd1;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: ;
            endcase

            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        aa_q      <= acc_addr;
                        len_q     <= pdu_len;
                        crc       <= CRC_INIT;
                        bit_cnt   <= 5'd0;
                        byte_cnt  <= 9'd0;
                        fetch_cnt <= 9'd0;
                        state     <= S_PREAMBLE;
                    end
                end
                S_PREAMBLE: begin
                    if (strobe) begin
                        symbol_out <= aa_q[31] ^ bit_cnt[0];
                        tx_active  <= 1'b1;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt <= 5'd0;
                            state   <= S_ACCESS;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                S_ACCESS: begin
                    if (strobe) begin
                        symbol_out <= aa_q[31];
                        aa_q       <= {aa_q[30:0], 1'b0};
                        if (bit_cnt == 5'd31) begin
                            bit_cnt <= 5'd0;
                            state   <= S_PDU;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                S_PDU: begin
                    if (starve) begin
                        state      <= S_IDLE;
                        symbol_out <= 1'b0;
                        tx_active  <= 1'b0;
                        underrun   <= 1'b1;
                        bit_cnt    <= 5'd0;
                        byte_cnt   <= 9'd0;
                        fifo_cnt   <= 2'd0;
                        wr_ptr     <= 1'b0;
                        rd_ptr     <= 1'b0;
                    end else if (strobe) begin
                        symbol_out <= pdu_bit ^ white;
                        crc        <= crc_next;
                        cur_byte   <= (bit_cnt[2:0] == 3'd0) ? {fifo[rd_ptr][6:0], 1'b0}
                                                             : {cur_byte[6:0], 1'b0};
                        if (bit_cnt[2:0] == 3'd7) begin
                            bit_cnt  <= 5'd0;
                            byte_cnt <= byte_cnt + 9'd1;
                            if ((byte_cnt + 9'd1) == len_q) begin
                                state <= S_CRC;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                S_CRC: begin
                    if (strobe) begin
                        if (bit_cnt == 5'd24) begin
                            state      <= S_IDLE;
                            symbol_out <= 1'b0;
                            tx_active  <= 1'b0;
                            done       <= 1'b1;
                            bit_cnt    <= 5'd0;
                            byte_cnt   <= 9'd0;
                        end else begin
                            symbol_out <= crc[23] ^ white;
                            crc        <= {crc[22:0], 1'b0};
                            bit_cnt    <= bit_cnt + 5'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_packet_transmitter.sv
// Directed bench for packet_transmitter; the reference symbol stream follows
// the PACKET_TX_WHITEN_EN setting of the build.
module tb_packet_transmitter;
    localparam logic [23:0] POLY = 24'h00065B;
`ifdef PACKET_TX_WHITEN_EN
    localparam bit WHITEN = 1'b1;
`else
    localparam bit WHITEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, en, symbol_clk, start, pdu_valid;
    logic [31:0] acc_addr;
    logic [5:0]  channel;
    logic [8:0]  pdu_len;
    logic [7:0]  pdu_data;
    logic        pdu_ready, symbol_out, tx_active, busy, done, underrun;

    int          checks;
    int          failures;
    bit          got_sym [0:2299];
    bit          exp_sym [0:2299];
    logic [7:0]  tx_bytes [0:256];
    int          n_sym, done_at, und_at, hs_cnt;

    packet_transmitter dut (
        .clk(clk), .rst(rst), .en(en), .symbol_clk(symbol_clk), .start(start),
        .acc_addr(acc_addr), .channel(channel), .pdu_len(pdu_len),
        .pdu_data(pdu_data), .pdu_valid(pdu_valid), .pdu_ready(pdu_ready),
        .symbol_out(symbol_out), .tx_active(tx_active), .busy(busy),
        .done(done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic build_expected(input logic [31:0] aa, input logic [5:0] ch, input int len);
        int k;
        logic [23:0] crc;
        logic [6:0] lf;
        logic raw, fb, w;
        k = 0;
        for (int i = 0; i < 8; i++) begin exp_sym[k] = aa[31] ^ i[0]; k++; end
        for (int i = 31; i >= 0; i--) begin exp_sym[k] = aa[i]; k++; end
        crc = 24'h555555;
        lf = {1'b1, ch};
        for (int by = 0; by < len; by++) begin
            for (int b = 7; b >= 0; b--) begin
                raw = tx_bytes[by][b];
                fb = crc[23] ^ raw;
                crc = {crc[22:0], 1'b0} ^ (fb ? POLY : 24'h0);
                w = WHITEN & lf[0];
                lf = {lf[0], lf[6:1]};
                lf[2] = lf[2] ^ lf[6];
                exp_sym[k] = raw ^ w;
                k++;
            end
        end
        for (int i = 23; i >= 0; i--) begin
            w = WHITEN & lf[0];
            lf = {lf[0], lf[6:1]};
            lf[2] = lf[2] ^ lf[6];
            exp_sym[k] = crc[i] ^ w;
            k++;
        end
    endtask

    function automatic int first_diff(input int n);
        for (int i = 0; i < n; i++) if (got_sym[i] !== exp_sym[i]) return i;
        return -1;
    endfunction

    task automatic begin_packet(input logic [31:0] aa, input logic [5:0] ch, input logic [8:0] len);
        start = 1'b1; acc_addr = aa; channel = ch; pdu_len = len;
        symbol_clk = 1'b1; en = 1'b1; pdu_valid = 1'b0;
        @(negedge clk);
        start = 1'b0; symbol_clk = 1'b0;
    endtask

    // Cycle loop: symbol strobe every 4th clk, byte source, optional pause/restart.
    task automatic run_packet(input int src_limit, input int pause_at, input int pause_len,
                              input int restart_at, input int stop_s, input int budget);
        int s, cyc, pause_left, src_idx;
        bit strobe_now, finished;
        s = 0; cyc = 0; src_idx = 0; pause_left = pause_len; finished = 0;
        n_sym = 0; done_at = -1; und_at = -1;
        while (!finished && cyc < budget) begin
            symbol_clk = ((cyc % 4) == 3);
            en = !(pause_left > 0 && s == pause_at);
            if (!en && symbol_clk) pause_left--;
            if (restart_at >= 0 && s == restart_at && (cyc % 4) == 1) begin
                start = 1'b1; acc_addr = 32'h12345678; pdu_len = 9'd3; channel = 6'd5;
            end
            pdu_valid = (src_idx < src_limit);
            pdu_data = pdu_valid ? tx_bytes[src_idx] : 8'h00;
            #1;
            if (pdu_valid && pdu_ready) src_idx++;
            strobe_now = en && symbol_clk;
            @(negedge clk);
            start = 1'b0;
            if (strobe_now) begin
                s++;
                if (tx_active && n_sym < 2300) begin got_sym[n_sym] = symbol_out; n_sym++; end
            end
            if (done) begin done_at = s; finished = 1; end
            if (underrun) begin und_at = s; finished = 1; end
            if (stop_s >= 0 && s >= stop_s) finished = 1;
            cyc++;
        end
        hs_cnt = src_idx;
        pdu_valid = 1'b0; symbol_clk = 1'b0; en = 1'b1;
    endtask

    task automatic test_reset();
        int d;
        checks++;
        if ({symbol_out, tx_active, busy, done, underrun, pdu_ready} !== 6'b0) begin
            failures++;
            $display("FAIL reset_values got=%b want=000000",
                     {symbol_out, tx_active, busy, done, underrun, pdu_ready});
        end
        rst = 1'b0;
        @(negedge clk);
        tx_bytes[0] = 8'h11; tx_bytes[1] = 8'h22; tx_bytes[2] = 8'h33;
        begin_packet(32'h8E89BED6, 6'd37, 9'd3);
        run_packet(3, -1, 0, -1, 20, 400);
        checks++;
        if (tx_active !== 1'b1) begin
            failures++; $display("FAIL pre_reset_tx_active got=%b want=1", tx_active);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({symbol_out, tx_active, busy, done, underrun, pdu_ready} !== 6'b0) begin
            failures++;
            $display("FAIL reset_mid_packet got=%b want=000000",
                     {symbol_out, tx_active, busy, done, underrun, pdu_ready});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, underrun} !== 3'b0) begin
            failures++; $display("FAIL reset_no_pulse got=%b want=000", {busy, done, underrun});
        end
        build_expected(32'h8E89BED6, 6'd37, 3);
        begin_packet(32'h8E89BED6, 6'd37, 9'd3);
        run_packet(3, -1, 0, -1, -1, 600);
        checks++;
        if (n_sym != 88) begin failures++; $display("FAIL after_reset_len got=%0d want=88", n_sym); end
        d = first_diff(88);
        checks++;
        if (d != -1) begin failures++; $display("FAIL after_reset_stream first_bad_index=%0d want=-1", d); end
        checks++;
        if (done_at != 89) begin failures++; $display("FAIL after_reset_done got=%0d want=89", done_at); end
    endtask

    task automatic test_preamble();
        logic [15:0] got16;
        tx_bytes[0] = 8'h00; tx_bytes[1] = 8'h00;
        begin_packet(32'h8E89BED6, 6'd1, 9'd2);
        run_packet(2, -1, 0, -1, -1, 500);
        for (int i = 0; i < 16; i++) got16[15 - i] = got_sym[i];
        checks++;
        if (got16 !== 16'hAA8E) begin failures++; $display("FAIL preamble_8e got=%h want=aa8e", got16); end
        begin_packet(32'h0E89BED6, 6'd1, 9'd2);
        run_packet(2, -1, 0, -1, -1, 500);
        for (int i = 0; i < 16; i++) got16[15 - i] = got_sym[i];
        checks++;
        if (got16 !== 16'h550E) begin failures++; $display("FAIL preamble_0e got=%h want=550e", got16); end
    endtask

    task automatic test_loopback();
        int d;
        tx_bytes[0] = 8'h00; tx_bytes[1] = 8'h00;
        build_expected(32'h8E89BED6, 6'd37, 2);
        begin_packet(32'h8E89BED6, 6'd37, 9'd2);
        run_packet(2, -1, 0, -1, -1, 500);
        checks++;
        if (n_sym != 80) begin failures++; $display("FAIL loop_len got=%0d want=80", n_sym); end
        checks++;
        if (done_at != 81) begin failures++; $display("FAIL loop_done got=%0d want=81", done_at); end
        d = first_diff(80);
        checks++;
        if (d != -1) begin failures++; $display("FAIL loop_stream first_bad_index=%0d want=-1", d); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL loop_busy_end got=%b want=0", busy); end
    endtask

    task automatic test_max_len();
        int d;
        for (int i = 0; i < 257; i++) tx_bytes[i] = i[7:0];
        build_expected(32'h8E89BED6, 6'd22, 257);
        begin_packet(32'h8E89BED6, 6'd22, 9'd257);
        run_packet(257, -1, 0, -1, -1, 9000);
        checks++;
        if (hs_cnt != 257) begin failures++; $display("FAIL max_handshakes got=%0d want=257", hs_cnt); end
        checks++;
        if (n_sym != 2120) begin failures++; $display("FAIL max_len got=%0d want=2120", n_sym); end
        d = first_diff(2120);
        checks++;
        if (d != -1) begin failures++; $display("FAIL max_stream first_bad_index=%0d want=-1", d); end
        checks++;
        if (done_at != 2121) begin failures++; $display("FAIL max_done got=%0d want=2121", done_at); end
    endtask

    task automatic test_underrun();
        int d;
        tx_bytes[0] = 8'hC3; tx_bytes[1] = 8'h5A; tx_bytes[2] = 8'h0F; tx_bytes[3] = 8'hF0;
        build_expected(32'h8E89BED6, 6'd9, 4);
        begin_packet(32'h8E89BED6, 6'd9, 9'd4);
        run_packet(1, -1, 0, -1, -1, 600);
        checks++;
        if (und_at != 49) begin failures++; $display("FAIL underrun_at got=%0d want=49", und_at); end
        checks++;
        if (done_at != -1) begin failures++; $display("FAIL underrun_done got=%0d want=-1", done_at); end
        checks++;
        if ({tx_active, symbol_out} !== 2'b00) begin
            failures++; $display("FAIL underrun_outputs got=%b want=00", {tx_active, symbol_out});
        end
        d = first_diff(48);
        checks++;
        if (n_sym != 48 || d != -1) begin
            failures++; $display("FAIL underrun_stream got_len=%0d bad=%0d want_len=48 bad=-1", n_sym, d);
        end
        @(negedge clk);
        checks++;
        if ({busy, underrun} !== 2'b00) begin
            failures++; $display("FAIL underrun_idle got=%b want=00", {busy, underrun});
        end
    endtask

    task automatic test_ignore_and_pause();
        int d;
        tx_bytes[0] = 8'hA5; tx_bytes[1] = 8'h3C;
        build_expected(32'h8E89BED6, 6'd17, 2);
        begin_packet(32'h8E89BED6, 6'd17, 9'd2);
        run_packet(2, -1, 0, 20, -1, 500);
        d = first_diff(80);
        checks++;
        if (n_sym != 80 || d != -1) begin
            failures++; $display("FAIL restart_ignored got_len=%0d bad=%0d want_len=80 bad=-1", n_sym, d);
        end
        checks++;
        if (done_at != 81) begin failures++; $display("FAIL restart_done got=%0d want=81", done_at); end
        tx_bytes[0] = 8'h96; tx_bytes[1] = 8'h01; tx_bytes[2] = 8'h80; tx_bytes[3] = 8'h7E;
        build_expected(32'h71764129, 6'd33, 4);
        begin_packet(32'h71764129, 6'd33, 9'd4);
        run_packet(4, 50, 10, -1, -1, 700);
        d = first_diff(96);
        checks++;
        if (n_sym != 96 || d != -1) begin
            failures++; $display("FAIL pause_stream got_len=%0d bad=%0d want_len=96 bad=-1", n_sym, d);
        end
        checks++;
        if (done_at != 97) begin failures++; $display("FAIL pause_done got=%0d want=97", done_at); end
        begin_packet(32'h8E89BED6, 6'd1, 9'd1);
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL len1_busy got=%b want=0", busy); end
        begin_packet(32'h8E89BED6, 6'd1, 9'd258);
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL len258_busy got=%b want=0", busy); end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; en = 1'b1; symbol_clk = 1'b0; start = 1'b0; acc_addr = 32'd0;
        channel = 6'd0; pdu_len = 9'd0; pdu_data = 8'd0; pdu_valid = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_preamble();
        test_loopback();
        test_max_len();
        test_underrun();
        test_ignore_and_pause();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
